// File: rtl/regfile_bist_pkg.sv
// rtl/regfile_bist_pkg.sv - shared state encoding, error width and pattern function for regfile_bist
package regfile_bist_pkg;

  localparam int ERR_W = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WRITE,
    ST_RADDR,
    ST_RCHK,
    ST_DONE
  } state_e;

  // Pass 1 inverts the pass-0 pattern so every cell sees both polarities.
  function automatic logic [31:0] pattern_fn(input logic [31:0] base,
                                             input logic [31:0] r,
                                             input logic        p);
    return (base ^ r) ^ {32{p}};
  endfunction

endpackage

// File: rtl/regfile_bist_if.sv
// rtl/regfile_bist_if.sv - control/status and regfile-port bundle between regfile_bist and its surroundings
interface regfile_bist_if
  import regfile_bist_pkg::*;
#(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
);
  logic              start;
  logic              busy;
  logic              done;
  logic              pass;
  logic [ERR_W-1:0]  err_count;
  logic [ADDR_W-1:0] first_err_reg;
  logic [DATA_W-1:0] first_err_data;
  logic              ctrl_writeEn;
  logic [ADDR_W-1:0] ctrl_writeReg;
  logic [DATA_W-1:0] data_writeReg;
  logic [ADDR_W-1:0] ctrl_readRegA;
  logic [ADDR_W-1:0] ctrl_readRegB;
  logic [DATA_W-1:0] data_readRegA;
  logic [DATA_W-1:0] data_readRegB;

  modport master (
    input  start, data_readRegA, data_readRegB,
    output busy, done, pass, err_count, first_err_reg, first_err_data,
           ctrl_writeEn, ctrl_writeReg, data_writeReg, ctrl_readRegA, ctrl_readRegB
  );

  modport slave (
    output start, data_readRegA, data_readRegB,
    input  busy, done, pass, err_count, first_err_reg, first_err_data,
           ctrl_writeEn, ctrl_writeReg, data_writeReg, ctrl_readRegA, ctrl_readRegB
  );
endinterface

// File: rtl/regfile_bist_pattern.sv
// rtl/regfile_bist_pattern.sv - combinational (register, pass) -> write data and expected read data
module regfile_bist_pattern
  import regfile_bist_pkg::*;
#(
  parameter int          ADDR_W  = 5,
  parameter int          DATA_W  = 32,
  parameter logic [31:0] PATTERN = 32'h0000DEAD,
  parameter int          R0_ZERO = 1
) (
  input  logic [ADDR_W:0]   reg_idx,
  input  logic              pass_idx,
  output logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] exp_data
);
  logic [31:0] full_w;

  always_comb begin
    full_w   = pattern_fn(PATTERN, 32'(reg_idx), pass_idx);
    wdata    = full_w[DATA_W-1:0];
    // A hardwired r0 still receives the pattern write but must read back zero.
    exp_data = ((R0_ZERO != 0) && (reg_idx == '0)) ? '0 : wdata;
  end
endmodule

// File: rtl/regfile_bist.sv
// rtl/regfile_bist.sv - two-pass write/read-back self test of the 32x32 register file
// Optional REGFILE_BIST_PORTB_EN also checks read port B data.
module regfile_bist
  import regfile_bist_pkg::*;
#(
  parameter int          NUM_REGS = 32,
  parameter int          ADDR_W   = 5,
  parameter int          DATA_W   = 32,
  parameter logic [31:0] PATTERN  = 32'h0000DEAD,
  parameter int          R0_ZERO  = 1
) (
  input  logic           clock,
  input  logic           ctrl_reset,
  regfile_bist_if.master bus
);
  localparam logic [ADDR_W:0] LAST = (ADDR_W+1)'(NUM_REGS - 1);
  localparam logic [ADDR_W:0] ONE  = (ADDR_W+1)'(1);

  state_e            state_q, state_d;
  logic [ADDR_W:0]   r_q, r_d;
  logic              p_q, p_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              pass_q, pass_d;
  logic [ERR_W-1:0]  err_q, err_d;
  logic [ADDR_W-1:0] ferr_reg_q, ferr_reg_d;
  logic [DATA_W-1:0] ferr_data_q, ferr_data_d;

  logic [DATA_W-1:0] wdata, exp_data;
  logic              mis_a, mis_b;
  logic [1:0]        n_mis;
  logic [ERR_W:0]    err_sum;
  logic              rd_phase;

  regfile_bist_pattern #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .PATTERN(PATTERN),
    .R0_ZERO(R0_ZERO)
  ) u_pattern (
    .reg_idx (r_q),
    .pass_idx(p_q),
    .wdata   (wdata),
    .exp_data(exp_data)
  );

  assign mis_a = (bus.data_readRegA != exp_data);
`ifdef REGFILE_BIST_PORTB_EN
  assign mis_b = (bus.data_readRegB != exp_data);
`else
  logic unused_portb;
  assign unused_portb = ^bus.data_readRegB;
  assign mis_b        = 1'b0;
`endif

  assign n_mis   = {1'b0, mis_a} + {1'b0, mis_b};
  assign err_sum = {1'b0, err_q} + (ERR_W+1)'(n_mis);

  always_comb begin
    state_d     = state_q;
    r_d         = r_q;
    p_d         = p_q;
    done_d      = 1'b0;
    pass_d      = pass_q;
    err_d       = err_q;
    ferr_reg_d  = ferr_reg_q;
    ferr_data_d = ferr_data_q;
    case (state_q)
      ST_IDLE: if (bus.start) begin
        state_d     = ST_WRITE;
        r_d         = '0;
        p_d         = 1'b0;
        pass_d      = 1'b0;
        err_d       = '0;
        ferr_reg_d  = '0;
        ferr_data_d = '0;
      end
      ST_WRITE: begin
        state_d = (r_q == LAST) ? ST_RADDR : ST_WRITE;
        r_d     = (r_q == LAST) ? '0 : r_q + ONE;
      end
      ST_RADDR: state_d = ST_RCHK;
      ST_RCHK: begin
        if (n_mis != 2'd0) begin
          err_d = err_sum[ERR_W] ? '1 : err_sum[ERR_W-1:0];
          // Only the very first failing register is recorded; port A wins a tie.
          if (err_q == '0) begin
            ferr_reg_d  = r_q[ADDR_W-1:0];
            ferr_data_d = mis_a ? bus.data_readRegA : bus.data_readRegB;
          end
        end
        if (r_q == LAST) begin
          r_d     = '0;
          p_d     = 1'b1;
          state_d = p_q ? ST_DONE : ST_WRITE;
        end else begin
          r_d     = r_q + ONE;
          state_d = ST_RADDR;
        end
      end
      ST_DONE: begin
        done_d  = 1'b1;
        pass_d  = (err_q == '0);
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clock) begin
    if (ctrl_reset) begin
      state_q     <= ST_IDLE;
      r_q         <= '0;
      p_q         <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
      err_q       <= '0;
      ferr_reg_q  <= '0;
      ferr_data_q <= '0;
    end else begin
      state_q     <= state_d;
      r_q         <= r_d;
      p_q         <= p_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      pass_q      <= pass_d;
      err_q       <= err_d;
      ferr_reg_q  <= ferr_reg_d;
      ferr_data_q <= ferr_data_d;
    end
  end

  // Regfile controls decode straight from state so reset drops writeEn on the same edge.
  assign rd_phase           = (state_q == ST_RADDR) || (state_q == ST_RCHK);
  assign bus.ctrl_writeEn   = (state_q == ST_WRITE);
  assign bus.ctrl_writeReg  = bus.ctrl_writeEn ? r_q[ADDR_W-1:0] : '0;
  assign bus.data_writeReg  = bus.ctrl_writeEn ? wdata : '0;
  assign bus.ctrl_readRegA  = rd_phase ? r_q[ADDR_W-1:0] : '0;
  assign bus.ctrl_readRegB  = bus.ctrl_readRegA;
  assign bus.busy           = busy_q;
  assign bus.done           = done_q;
  assign bus.pass           = pass_q;
  assign bus.err_count      = err_q;
  assign bus.first_err_reg  = ferr_reg_q;
  assign bus.first_err_data = ferr_data_q;
endmodule

// File: tb/tb_regfile_bist.sv
// tb/tb_regfile_bist.sv - directed self-checking bench for regfile_bist with a faultable regfile model
module tb_regfile_bist;
  import regfile_bist_pkg::*;

`ifdef REGFILE_BIST_PORTB_EN
  localparam int PB = 2;
`else
  localparam int PB = 1;
`endif

  logic clock = 1'b0;
  logic ctrl_reset;
  logic clear_mem;
  int   fault_mode;
  int   checks   = 0;
  int   failures = 0;
  logic [31:0] mem [32];
  logic [31:0] rd_a, rd_b;

  always #5 clock = ~clock;

  regfile_bist_if #(.ADDR_W(5), .DATA_W(32)) bus ();

  regfile_bist dut (
    .clock     (clock),
    .ctrl_reset(ctrl_reset),
    .bus       (bus)
  );

  // Regfile model: 1 = reg7 bit3 stuck low, 2 = reg7 bit3 stuck high,
  // 3 = writes to reg5 land on reg4, 4 = port B of reg12 has bit0 flipped.
  always @(posedge clock) begin
    if (clear_mem) begin
      for (int i = 0; i < 32; i++) mem[i] <= 32'h0;
    end else if (bus.ctrl_writeEn) begin
      if (fault_mode == 3 && bus.ctrl_writeReg == 5'd5) mem[4] <= bus.data_writeReg;
      else mem[bus.ctrl_writeReg] <= bus.data_writeReg;
    end
  end

  always_comb begin
    rd_a = (bus.ctrl_readRegA == 5'd0) ? 32'h0 : mem[bus.ctrl_readRegA];
    rd_b = (bus.ctrl_readRegB == 5'd0) ? 32'h0 : mem[bus.ctrl_readRegB];
    if (fault_mode == 1 && bus.ctrl_readRegA == 5'd7) rd_a[3] = 1'b0;
    if (fault_mode == 1 && bus.ctrl_readRegB == 5'd7) rd_b[3] = 1'b0;
    if (fault_mode == 2 && bus.ctrl_readRegA == 5'd7) rd_a[3] = 1'b1;
    if (fault_mode == 2 && bus.ctrl_readRegB == 5'd7) rd_b[3] = 1'b1;
    if (fault_mode == 4 && bus.ctrl_readRegB == 5'd12) rd_b[0] = ~rd_b[0];
    bus.data_readRegA = rd_a;
    bus.data_readRegB = rd_b;
  end

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_model;
    clear_mem = 1'b1;
    tick;
    clear_mem = 1'b0;
  endtask

  task automatic run_and_check(input string tag, input int exp_err,
                               input logic [31:0] exp_reg, input logic [31:0] exp_data);
    int k;
    k = 0;
    bus.start = 1'b1;
    tick;
    bus.start = 1'b0;
    while (bus.busy === 1'b1 && k < 1000) begin
      if (k == 0) begin
        check({tag, "/wr0_en"},   32'(bus.ctrl_writeEn), 32'd1);
        check({tag, "/wr0_reg"},  32'(bus.ctrl_writeReg), 32'd0);
        check({tag, "/wr0_data"}, bus.data_writeReg, 32'h0000DEAD);
      end
      if (k == 35) begin
        check({tag, "/rchk1_en"}, 32'(bus.ctrl_writeEn), 32'd0);
        check({tag, "/rchk1_a"},  32'(bus.ctrl_readRegA), 32'd1);
        check({tag, "/rchk1_b"},  32'(bus.ctrl_readRegB), 32'd1);
      end
      if (k == 97) begin
        check({tag, "/p1wr1_reg"},  32'(bus.ctrl_writeReg), 32'd1);
        check({tag, "/p1wr1_data"}, bus.data_writeReg, 32'hFFFF2153);
      end
      k++;
      tick;
    end
    check({tag, "/busy_cycles"}, 32'(k), 32'd193);
    check({tag, "/done"},        32'(bus.done), 32'd1);
    check({tag, "/pass"},        32'(bus.pass), (exp_err == 0) ? 32'd1 : 32'd0);
    check({tag, "/err_count"},   32'(bus.err_count), 32'(exp_err));
    check({tag, "/first_reg"},   32'(bus.first_err_reg), exp_reg);
    check({tag, "/first_data"},  bus.first_err_data, exp_data);
    tick;
    check({tag, "/done_pulse"},  32'(bus.done), 32'd0);
    check({tag, "/pass_held"},   32'(bus.pass), (exp_err == 0) ? 32'd1 : 32'd0);
  endtask

  initial begin
    int done_cnt, rises;
    logic prev_busy;

    bus.start  = 1'b0;
    fault_mode = 0;
    ctrl_reset = 1'b1;
    clear_mem  = 1'b1;
    repeat (3) tick;
    ctrl_reset = 1'b0;
    clear_mem  = 1'b0;

    check("rst/busy",       32'(bus.busy), 32'd0);
    check("rst/done",       32'(bus.done), 32'd0);
    check("rst/pass",       32'(bus.pass), 32'd0);
    check("rst/err_count",  32'(bus.err_count), 32'd0);
    check("rst/first_reg",  32'(bus.first_err_reg), 32'd0);
    check("rst/first_data", bus.first_err_data, 32'd0);
    check("rst/wr_en",      32'(bus.ctrl_writeEn), 32'd0);
    check("rst/wr_reg",     32'(bus.ctrl_writeReg), 32'd0);
    check("rst/wr_data",    bus.data_writeReg, 32'd0);
    check("rst/rd_a",       32'(bus.ctrl_readRegA), 32'd0);
    check("rst/rd_b",       32'(bus.ctrl_readRegB), 32'd0);

    run_and_check("good", 0, 32'd0, 32'h0);

    // Stuck low: pass-0 reg7 expects 0xDEAA, reads 0xDEA2; pass 1 (bit3=0) is clean.
    fault_mode = 1;
    clear_model;
    run_and_check("stuck0", PB, 32'd7, 32'h0000DEA2);

    // Stuck high: pass 0 is clean; pass-1 reg7 expects 0xFFFF2155, reads 0xFFFF215D.
    fault_mode = 2;
    clear_model;
    run_and_check("stuck1", PB, 32'd7, 32'hFFFF215D);

    // Alias: reg4 ends up holding reg5's data (0xDEA8); reg5 stays at its cleared 0.
    fault_mode = 3;
    clear_model;
    run_and_check("alias", 4 * PB, 32'd4, 32'h0000DEA8);

    // Port-B-only corruption of reg12: 0xDEA1 reads back as 0xDEA0 on port B.
    fault_mode = 4;
    clear_model;
`ifdef REGFILE_BIST_PORTB_EN
    run_and_check("portb", 2, 32'd12, 32'h0000DEA0);
`else
    run_and_check("portb", 0, 32'd0, 32'h0);
`endif

    // Reset during the pass-1 write sweep aborts without a done pulse.
    fault_mode = 0;
    bus.start = 1'b1;
    tick;
    bus.start = 1'b0;
    repeat (99) tick;
    check("abort/in_write", 32'(bus.ctrl_writeEn), 32'd1);
    ctrl_reset = 1'b1;
    tick;
    check("abort/wr_en",     32'(bus.ctrl_writeEn), 32'd0);
    check("abort/busy",      32'(bus.busy), 32'd0);
    check("abort/done",      32'(bus.done), 32'd0);
    ctrl_reset = 1'b0;
    done_cnt = 0;
    for (int i = 0; i < 300; i++) begin
      tick;
      if (bus.done === 1'b1) done_cnt++;
    end
    check("abort/no_done",   32'(done_cnt), 32'd0);
    run_and_check("after_abort", 0, 32'd0, 32'h0);

    // Held and re-pulsed start must produce exactly one run.
    done_cnt  = 0;
    rises     = 0;
    prev_busy = bus.busy;
    for (int i = 0; i < 400; i++) begin
      bus.start = (i < 10 || i == 60) ? 1'b1 : 1'b0;
      tick;
      if (bus.done === 1'b1) done_cnt++;
      if (bus.busy === 1'b1 && prev_busy !== 1'b1) rises++;
      prev_busy = bus.busy;
    end
    bus.start = 1'b0;
    check("held/done_pulses", 32'(done_cnt), 32'd1);
    check("held/busy_rises",  32'(rises), 32'd1);
    check("held/pass",        32'(bus.pass), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
